// File: rtl/aes_round_sched.sv
// ============================================================================
// Module   : aes_round_sched
// Brief    : Control FSM sequencing AES-128 key expansion, pre-add and rounds
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_round_sched #(
    parameter int NUM_ROUNDS  = 10,
    parameter int KEY_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       chg_key,
    input  logic       change_key_done,
    input  logic       blk_valid,
    output logic       blk_ready,
    output logic       pre_add_en,
    output logic       round_en,
    output logic [3:0] cur_round,
    output logic       last_round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       key_loaded,
    output logic       key_err,
    output logic       busy
);

    localparam int TO_W = $clog2(KEY_TIMEOUT + 1);
    localparam logic [3:0]      c_LAST_RND = 4'(NUM_ROUNDS);
    localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(KEY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEY_EXP = 3'd1,
        S_PRE_ADD = 3'd2,
        S_ROUND   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_rnd_cnt, w_rnd_cnt_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic            r_key_loaded, w_key_loaded_nxt;
    logic            r_key_err, w_key_err_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_rnd_cnt    <= 4'd0;
            r_to_cnt     <= '0;
            r_key_loaded <= 1'b0;
            r_key_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rnd_cnt    <= w_rnd_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_key_loaded <= w_key_loaded_nxt;
            r_key_err    <= w_key_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rnd_cnt_nxt    = r_rnd_cnt;
        w_to_cnt_nxt     = r_to_cnt;
        w_key_loaded_nxt = r_key_loaded;
        w_key_err_nxt    = r_key_err;
        case (r_state)
            S_IDLE: begin
                // A pending key always takes priority over a waiting block
                if (key_valid) begin
                    w_state_nxt      = S_KEY_EXP;
                    w_key_loaded_nxt = 1'b0;
                    w_key_err_nxt    = 1'b0;
                    w_to_cnt_nxt     = '0;
                end else if (blk_valid && r_key_loaded) begin
                    w_state_nxt   = S_PRE_ADD;
                    w_rnd_cnt_nxt = 4'd0;
                end
            end
            S_KEY_EXP: begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
                if (change_key_done) begin
                    w_key_loaded_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_key_err_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_PRE_ADD: begin
                w_state_nxt   = S_ROUND;
                w_rnd_cnt_nxt = 4'd1;
            end
            S_ROUND: begin
                if (r_rnd_cnt < c_LAST_RND) begin
                    w_rnd_cnt_nxt = r_rnd_cnt + 4'd1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt   = S_IDLE;
                    w_rnd_cnt_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_rnd_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign key_ready  = (r_state == S_IDLE);
    assign blk_ready  = (r_state == S_IDLE) && r_key_loaded && !key_valid;
    assign chg_key    = (r_state == S_KEY_EXP);
    assign pre_add_en = (r_state == S_PRE_ADD);
    assign round_en   = (r_state == S_ROUND);
    assign last_round = (r_state == S_ROUND) && (r_rnd_cnt == c_LAST_RND);
    assign out_valid  = (r_state == S_DONE);
    assign cur_round  = r_rnd_cnt;
    assign key_loaded = r_key_loaded;
    assign key_err    = r_key_err;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
